delay_line_var: RTL and testbench

Runtime-programmable, RAM-based sample delay line for the EthCore datapath: every sample accepted on `d` reappears on `q` exactly N accepted samples later. N is loadable at run time between 2 and MAX_DEPTH. A clock-enable input lets the line advance only on valid samples. A `q_valid` flag marks when the line has been refilled after reset or a delay change. This block generalises the fixed-depth, free-running delay memory used in the receive path.

---
 rtl/delay_line_pkg.sv | 25 ++
 rtl/ram2port.sv | 37 +++
 rtl/delay_line_var.sv | 114 +++++++++++
 tb/tb_delay_line_var.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | delay_line_pkg: shared constants and helpers for delay_line_var      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package delay_line_pkg;

   localparam int MIN_DELAY = 2;

   function automatic int clamp_delay(input int value, input int max_value);
      if (value < MIN_DELAY)
         return MIN_DELAY;
      else if (value > max_value)
         return max_value;
      else
         return value;
   endfunction

   // Increment with wrap at an arbitrary (not necessarily power-of-two) depth
   function automatic int ptr_wrap(input int ptr, input int depth);
      return (ptr + 1 >= depth) ? 0 : ptr + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram2port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram2port: simple dual-port RAM, write port A, registered read port B |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram2port #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             i_a_ce,
   input  logic             i_a_we,
   input  logic [AW-1:0]    i_a_addr,
   input  logic [WIDTH-1:0] i_a_din,
   input  logic             i_b_ce,
   input  logic [AW-1:0]    i_b_addr,
   output logic [WIDTH-1:0] o_b_dout
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_dout;

   always_ff @(posedge clk) begin
      if (i_a_ce && i_a_we)
         r_mem[i_a_addr] <= i_a_din;
   end

   always_ff @(posedge clk) begin
      if (i_b_ce)
         r_dout <= r_mem[i_b_addr];
   end

   assign o_b_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/delay_line_var.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | delay_line_var: run-time programmable RAM-based sample delay line.   |
// | Option macro DELAY_LINE_VAR_CLEAR_EN: force q to 0 while not valid.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module delay_line_var
   import delay_line_pkg::*;
#(
   parameter  int WIDTH         = 8,
   parameter  int MAX_DEPTH     = 64,
   parameter  int DEFAULT_DELAY = 4,
   localparam int DW            = $clog2(MAX_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   input  logic [DW-1:0]    delay_set,
   input  logic             delay_load,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic [DW-1:0]    delay_cur
);

   localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

   logic [DW-1:0]    r_delay;
   logic [DW-1:0]    r_fill;
   logic             r_q_valid;
   logic [WIDTH-1:0] r_q;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;

   logic [DW-1:0]    w_delay_new;
   logic [AW-1:0]    w_rseed;
   logic [AW-1:0]    w_waddr;
   logic [AW-1:0]    w_raddr;
   logic             w_qv_next;
   logic [DW-1:0]    w_fill_next;
   logic [WIDTH-1:0] w_rdata;

   assign w_delay_new = DW'(clamp_delay(int'(delay_set), MAX_DEPTH));
   // Read trails write by N-1 so the RAM read register plus r_q add up to N
   assign w_rseed     = AW'(MAX_DEPTH + 1 - int'(w_delay_new));

   always_comb begin
      w_waddr     = r_wptr;
      w_raddr     = r_rptr;
      w_qv_next   = r_q_valid;
      w_fill_next = r_fill;
      if (delay_load) begin
         w_waddr     = '0;
         w_raddr     = w_rseed;
         w_qv_next   = 1'b0;
         w_fill_next = ce ? DW'(1) : '0;
      end else if (ce) begin
         w_qv_next = (r_fill == r_delay);
         if (r_fill != r_delay)
            w_fill_next = r_fill + DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_delay   <= DW'(DEFAULT_DELAY);
         r_fill    <= '0;
         r_q_valid <= 1'b0;
         r_q       <= '0;
         r_wptr    <= '0;
         r_rptr    <= AW'(MAX_DEPTH + 1 - DEFAULT_DELAY);
      end else begin
         r_fill    <= w_fill_next;
         r_q_valid <= w_qv_next;
         if (delay_load)
            r_delay <= w_delay_new;
         if (ce) begin
            r_wptr <= AW'(ptr_wrap(int'(w_waddr), MAX_DEPTH));
            r_rptr <= AW'(ptr_wrap(int'(w_raddr), MAX_DEPTH));
         end else if (delay_load) begin
            r_wptr <= w_waddr;
            r_rptr <= w_raddr;
         end
`ifdef DELAY_LINE_VAR_CLEAR_EN
         if (ce || delay_load)
            r_q <= w_qv_next ? w_rdata : '0;
`else
         if (ce && !delay_load)
            r_q <= w_rdata;
`endif
      end
   end

   ram2port #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk      (clk),
      .i_a_ce   (ce),
      .i_a_we   (1'b1),
      .i_a_addr (w_waddr),
      .i_a_din  (d),
      .i_b_ce   (ce),
      .i_b_addr (w_raddr),
      .o_b_dout (w_rdata)
   );

   assign q         = r_q;
   assign q_valid   = r_q_valid;
   assign delay_cur = r_delay;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_var.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_delay_line_var: directed bench, one 64-deep and one 48-deep line   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_delay_line_var;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b0;
   logic       delay_load = 1'b0;
   logic [7:0] d = '0;
   logic [6:0] dset64 = '0;
   logic [5:0] dset48;
   logic [7:0] q0, q1;
   logic       qv0, qv1;
   logic [6:0] cur0;
   logic [5:0] cur1;

   // The 48-deep line has a 6-bit delay field: oversized requests saturate to 63
   assign dset48 = (dset64 > 7'd63) ? 6'd63 : dset64[5:0];

   always #5 clk = ~clk;

   delay_line_var #(.WIDTH(8), .MAX_DEPTH(64), .DEFAULT_DELAY(4)) u_dut64 (
      .clk(clk), .rst(rst), .ce(ce), .d(d), .delay_set(dset64),
      .delay_load(delay_load), .q(q0), .q_valid(qv0), .delay_cur(cur0));

   delay_line_var #(.WIDTH(8), .MAX_DEPTH(48), .DEFAULT_DELAY(4)) u_dut48 (
      .clk(clk), .rst(rst), .ce(ce), .d(d), .delay_set(dset48),
      .delay_load(delay_load), .q(q1), .q_valid(qv1), .delay_cur(cur1));

   typedef struct {
      bit             rst;
      bit             ce;
      bit             load;
      int             dset;
      logic [7:0]     d;
      logic [1:0][7:0] eq;
      bit   [1:0]     eqv;
      bit   [1:0]     eknown;
      int             ecur0;
      int             ecur1;
   } vec_t;

   vec_t tbl[$];
   int   nvec  = 0;
   int   nfail = 0;
   int   dctr  = 1;

   // Reference model: per-line history of samples accepted since reset/load
   int         m_depth [2] = '{64, 48};
   int         m_n     [2];
   int         m_cnt   [2];
   logic [7:0] m_q     [2];
   bit         m_qv    [2];
   bit         m_known [2];
   logic [7:0] m_hist  [2][1024];

   function automatic int ref_clamp(input int v, input int mx);
      if (v < 2) return 2;
      if (v > mx) return mx;
      return v;
   endfunction

   task automatic model_step(input int m, input bit r, input bit c, input bit l,
                             input int ds, input logic [7:0] dv);
      int eff;
      eff = (m == 1 && ds > 63) ? 63 : ds;
      if (r) begin
         m_n[m] = 4; m_cnt[m] = 0; m_q[m] = 8'd0; m_qv[m] = 1'b0; m_known[m] = 1'b1;
      end else begin
         if (l) begin
            m_n[m] = ref_clamp(eff, m_depth[m]);
            m_cnt[m] = 0;
            m_qv[m] = 1'b0;
`ifdef DELAY_LINE_VAR_CLEAR_EN
            m_q[m] = 8'd0; m_known[m] = 1'b1;
`endif
         end
         if (c) begin
            m_hist[m][m_cnt[m]] = dv;
            m_cnt[m]++;
            if (m_cnt[m] > m_n[m]) begin
               m_qv[m] = 1'b1; m_q[m] = m_hist[m][m_cnt[m] - 1 - m_n[m]]; m_known[m] = 1'b1;
            end else begin
               m_qv[m] = 1'b0;
`ifdef DELAY_LINE_VAR_CLEAR_EN
               m_q[m] = 8'd0; m_known[m] = 1'b1;
`else
               m_known[m] = 1'b0;
`endif
            end
         end
      end
   endtask

   task automatic add(input bit r, input bit c, input bit l, input int ds, input logic [7:0] dv);
      vec_t v;
      v.rst = r; v.ce = c; v.load = l; v.dset = ds; v.d = dv;
      for (int m = 0; m < 2; m++) begin
         model_step(m, r, c, l, ds, dv);
         v.eq[m] = m_q[m]; v.eqv[m] = m_qv[m]; v.eknown[m] = m_known[m];
      end
      v.ecur0 = m_n[0];
      v.ecur1 = m_n[1];
      tbl.push_back(v);
   endtask

   task automatic run(input int n, input bit rnd);
      for (int k = 0; k < n; k++) begin
         add(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 0, 8'(dctr));
         dctr++;
      end
   endtask

   task automatic load(input bit c, input int ds);
      add(1'b0, c, 1'b1, ds, 8'(dctr));
      if (c) dctr++;
   endtask

   task automatic check(input string name, input int idx, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s at vector %0d: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   initial begin
      // Hand sequence: power-up fill at the default delay of 4
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("reset q64", -1, int'(q0), 0);
      check("reset qv64", -1, int'(qv0), 0);
      check("reset cur64", -1, int'(cur0), 4);
      check("reset q48", -1, int'(q1), 0);
      check("reset qv48", -1, int'(qv1), 0);
      check("reset cur48", -1, int'(cur1), 4);
      rst = 1'b0; ce = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         d = 8'(k);
         @(posedge clk); #1;
         check("fill qv64", -k, int'(qv0), (k >= 5) ? 1 : 0);
         check("fill qv48", -k, int'(qv1), (k >= 5) ? 1 : 0);
         if (k >= 5) begin
            check("fill q64", -k, int'(q0), k - 4);
            check("fill q48", -k, int'(q1), k - 4);
         end
         @(negedge clk);
      end

      // Table of directed vectors with model-derived expectations
      add(1'b1, 1'b0, 1'b0, 0, 8'd0);
      run(10, 1'b0);
      load(1'b1, 64);  run(200, 1'b0);
      load(1'b1, 0);   run(8, 1'b0);
      load(1'b0, 100); run(70, 1'b0);
      load(1'b1, 5);   run(80, 1'b1);
      load(1'b1, 8);   run(20, 1'b0);
      load(1'b1, 3);   run(8, 1'b0);
      load(1'b1, 6);   load(1'b1, 2); run(5, 1'b0);
      load(1'b1, 2);   run(5, 1'b0);
      load(1'b1, 10);  run(4, 1'b0);
      add(1'b1, 1'b1, 1'b1, 30, 8'hEE); run(8, 1'b0);
      run(6, 1'b0);
      add(1'b1, 1'b1, 1'b0, 0, 8'hDD); run(8, 1'b0);
      load(1'b0, 7);   run(3, 1'b1); run(12, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rst; ce = tbl[i].ce; delay_load = tbl[i].load;
         dset64 = 7'(tbl[i].dset); d = tbl[i].d;
         @(posedge clk); #1;
         check("qv64", i, int'(qv0), int'(tbl[i].eqv[0]));
         check("cur64", i, int'(cur0), tbl[i].ecur0);
         if (tbl[i].eknown[0]) check("q64", i, int'(q0), int'(tbl[i].eq[0]));
         check("qv48", i, int'(qv1), int'(tbl[i].eqv[1]));
         check("cur48", i, int'(cur1), tbl[i].ecur1);
         if (tbl[i].eknown[1]) check("q48", i, int'(q1), int'(tbl[i].eq[1]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire
